wb_port_arbiter: RTL

- Owns the register-file write port behind the pipeline write-back stage.
- Performs the write-back data selection (ALU result vs. memory data) and arbitrates the single write port between two requesters: the pipeline WB stage and the debug/loader unit.
- The pipeline has priority. A starvation counter guarantees debug forward progress by stalling the pipeline for one cycle when needed.
- Write-port outputs are registered.

---
 rtl/wb_port_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port owner: selects write-back data and arbitrates the single
// write port between the pipeline WB stage and the debug/loader unit.
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [DATA_W-1:0] wb_alu_data,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic              wb_stall,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ack,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_PIPE = 2'd1;
    localparam logic [1:0] GRANT_DBG  = 2'd2;

    localparam int          CNT_W     = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic              pipe_eff;
    logic              dbg_live;
    logic              force_grant;
    logic              dbg_grant;
    logic              pipe_grant;
    logic [1:0]        grant_sel;
    logic [DATA_W-1:0] wb_sel_data;
    logic [CNT_W-1:0]  starve_cnt;

    // A pipeline write to register 0 is architecturally a no-op, so it never competes.
    assign pipe_eff    = wb_valid & wb_reg_write & (wb_rd != '0);
    assign dbg_live    = dbg_req & ~dbg_ack;
    assign force_grant = (starve_cnt == LIMIT);

    assign dbg_grant   = dbg_live & (~pipe_eff | force_grant);
    assign pipe_grant  = pipe_eff & ~dbg_grant;
    assign wb_stall    = dbg_grant & pipe_eff & Reset_n;

    assign wb_sel_data = wb_mem_to_reg ? wb_mem_data : wb_alu_data;

    always_comb begin
        grant_sel = GRANT_NONE;
        if (dbg_grant) begin
            grant_sel = GRANT_DBG;
        end else if (pipe_grant) begin
            grant_sel = GRANT_PIPE;
        end
    end

    // Address and data hold their last values when nobody is granted.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            dbg_ack  <= 1'b0;
        end else begin
            case (grant_sel)
                GRANT_PIPE: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= wb_rd;
                    rf_wdata <= wb_sel_data;
                    dbg_ack  <= 1'b0;
                end
                GRANT_DBG: begin
                    rf_we    <= (dbg_addr != '0);
                    rf_waddr <= dbg_addr;
                    rf_wdata <= dbg_data;
                    dbg_ack  <= 1'b1;
                end
                default: begin
                    rf_we    <= 1'b0;
                    dbg_ack  <= 1'b0;
                end
            endcase
        end
    end

    // Counts consecutive denied debug cycles; reaching the limit forces a debug grant.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            starve_cnt <= '0;
        end else if (dbg_grant || !dbg_live) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
